// File: rtl/prime_check_pkg.sv
// Shared definitions for the prime_check block and its divmod datapath.
//   PC_IDLE / PC_ISSUE / PC_WAIT : 2-bit FSM state encodings.
//   width_of()                   : operand width derived from WIDTH_LOG.
package prime_check_pkg;

  typedef logic [1:0] pc_state_t;

  localparam pc_state_t PC_IDLE  = 2'd0;
  localparam pc_state_t PC_ISSUE = 2'd1;
  localparam pc_state_t PC_WAIT  = 2'd2;

  function automatic int unsigned width_of(input int unsigned width_log);
    return 32'd1 << width_log;
  endfunction

endpackage

// File: rtl/prime_check_divmod.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH busy cycles.
// Ports:
//   clk, rst   : clock and synchronous active-high reset.
//   go         : start, sampled only while ready=1; a and b sampled with it.
//   a, b       : dividend, divisor.
//   ready      : idle; div/mod/error hold the last result.
//   div, mod   : quotient and remainder.
//   error      : last request had b == 0 (answered at once, no busy cycles).
module divmod
  import prime_check_pkg::*;
#(
  parameter int unsigned WIDTH_LOG = 4,
  localparam int unsigned WIDTH = width_of(WIDTH_LOG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] mod,
  output logic             error
);

  logic                 busy_q, busy_d;
  logic [WIDTH_LOG-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     den_q, den_d;
  logic                 err_q, err_d;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    err_d  = err_q;
    // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    // Only used when rem_sh >= den_q, where the true difference fits WIDTH bits.
    rem_sub = rem_sh[WIDTH-1:0] - den_q;
    if (busy_q) begin
      if (rem_sh >= {1'b0, den_q}) begin
        rem_d = rem_sub;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (go) begin
      if (b == '0) begin
        err_d = 1'b1;
        quo_d = '1;
        rem_d = a;
      end else begin
        err_d  = 1'b0;
        quo_d  = a;
        rem_d  = '0;
        den_d  = b;
        cnt_d  = WIDTH_LOG'(WIDTH - 1);
        busy_d = 1'b1;
      end
    end
  end

  always_comb begin
    ready = ~busy_q;
    div   = quo_q;
    mod   = rem_q;
    error = err_q;
  end

endmodule

// File: rtl/prime_check.sv
// Trial-division primality tester driving a private divmod unit.
// Ports:
//   clk, rst : clock and asynchronous active-high reset (also resets divmod).
//   go, n    : start request and candidate, sampled only while ready=1.
//   ready    : idle with results valid.
//   prime    : candidate is prime.
//   factor   : smallest nontrivial factor if composite, else 0.
//   trials   : divmod operations used for the last candidate.
module prime_check
  import prime_check_pkg::*;
#(
  parameter int unsigned WIDTH_LOG = 4,
  localparam int unsigned WIDTH = width_of(WIDTH_LOG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             prime,
  output logic [WIDTH-1:0] factor,
  output logic [WIDTH-1:0] trials
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] trials_q, trials_d;
  logic [WIDTH-1:0] factor_q, factor_d;
  logic             prime_q, prime_d;
  logic             ready_q, ready_d;

  logic             dm_go;
  logic             dm_ready;
  logic             dm_error;
  logic [WIDTH-1:0] dm_a, dm_b;
  logic [WIDTH-1:0] dm_div, dm_mod;

  divmod #(
    .WIDTH_LOG(WIDTH_LOG)
  ) dm (
    .clk  (clk),
    .rst  (rst),
    .go   (dm_go),
    .a    (dm_a),
    .b    (dm_b),
    .ready(dm_ready),
    .div  (dm_div),
    .mod  (dm_mod),
    .error(dm_error)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PC_IDLE;
      n_q      <= '0;
      d_q      <= '0;
      trials_q <= '0;
      factor_q <= '0;
      prime_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      trials_q <= trials_d;
      factor_q <= factor_d;
      prime_q  <= prime_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    trials_d = trials_q;
    factor_d = factor_q;
    prime_d  = prime_q;
    ready_d  = ready_q;
    unique case (state_q)
      PC_IDLE: begin
        if (!ready_q) begin
          // Trivial candidate resolved last cycle; results already in place.
          ready_d = 1'b1;
        end else if (go) begin
          n_d      = n;
          trials_d = '0;
          prime_d  = 1'b0;
          factor_d = '0;
          ready_d  = 1'b0;
          if (n < WIDTH'(2)) begin
            prime_d = 1'b0;
          end else if (n == WIDTH'(2)) begin
            prime_d = 1'b1;
          end else if (!n[0]) begin
            factor_d = WIDTH'(2);
          end else begin
            d_d     = WIDTH'(3);
            state_d = PC_ISSUE;
          end
        end
      end
      PC_ISSUE: begin
        if (dm_ready) begin
          trials_d = trials_q + WIDTH'(1);
          state_d  = PC_WAIT;
        end
      end
      PC_WAIT: begin
        if (dm_ready) begin
          if (dm_error) begin
            prime_d = 1'b0;
            ready_d = 1'b1;
            state_d = PC_IDLE;
          end else if (dm_div < d_q) begin
            // n/d < d means d*d > n: no factor left to find.
            prime_d  = 1'b1;
            factor_d = '0;
            ready_d  = 1'b1;
            state_d  = PC_IDLE;
          end else if (dm_mod == '0) begin
            prime_d  = 1'b0;
            factor_d = d_q;
            ready_d  = 1'b1;
            state_d  = PC_IDLE;
          end else begin
            d_d     = d_q + WIDTH'(2);
            state_d = PC_ISSUE;
          end
        end
      end
      default: begin
        state_d = PC_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    dm_go  = (state_q == PC_ISSUE) && dm_ready;
    dm_a   = n_q;
    dm_b   = d_q;
    ready  = ready_q;
    prime  = prime_q;
    factor = factor_q;
    trials = trials_q;
  end

  // Divisors start at 3, so a divide-by-zero response means corrupted state.
  a_no_dm_error: assert property (@(posedge clk) disable iff (rst)
      !((state_q == PC_WAIT) && dm_ready && dm_error))
    else $fatal(1, "prime_check: divmod reported divide-by-zero");

endmodule

// File: tb/tb_prime_check.sv
module tb_prime_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b0;
  logic [15:0] n   = '0;
  logic        ready;
  logic        prime;
  logic [15:0] factor;
  logic [15:0] trials;

  int checks   = 0;
  int failures = 0;
  int low_cyc;

  prime_check #(
    .WIDTH_LOG(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .n     (n),
    .ready (ready),
    .prime (prime),
    .factor(factor),
    .trials(trials)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; counts negedges with ready low, bounded by budget.
  task automatic wait_ready(input int budget, output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < budget) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with ready=1; issues go for one edge, then waits.
  task automatic run(input logic [15:0] v, input int budget, output int cyc);
    go = 1'b1;
    n  = v;
    @(negedge clk);
    go = 1'b0;
    wait_ready(budget, cyc);
  endtask

  task automatic run_check(input string tag, input logic [15:0] v, input logic exp_prime,
                           input logic [15:0] exp_factor, input logic [15:0] exp_trials);
    int cyc;
    run(v, 5000, cyc);
    check({tag, "_done"}, ready, 1'b1);
    check({tag, "_prime"}, prime, exp_prime);
    check({tag, "_factor"}, factor, exp_factor);
    check({tag, "_trials"}, trials, exp_trials);
  endtask

  logic [15:0] triv_n [4] = '{16'd0, 16'd1, 16'd2, 16'd4};
  logic        triv_p [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] triv_f [4] = '{16'd0, 16'd0, 16'd0, 16'd2};

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_prime", prime, 1'b0);
    check("rst_factor", factor, 16'd0);
    check("rst_trials", trials, 16'd0);

    // Asynchronous reset in the middle of a trial on 97.
    go = 1'b1;
    n  = 16'd97;
    @(negedge clk);
    go = 1'b0;
    check("busy_ready_low", ready, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_ready", ready, 1'b1);
    check("async_rst_trials", trials, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_prime", prime, 1'b0);
    check("post_rst_trials", trials, 16'd0);
    run_check("n97_after_rst", 16'd97, 1'b1, 16'd0, 16'd5);

    // Trivial candidates: ready low for exactly one cycle, no divmod.
    for (int i = 0; i < 4; i++) begin
      run(triv_n[i], 50, low_cyc);
      check($sformatf("triv%0d_lowcyc", triv_n[i]), low_cyc, 1);
      check($sformatf("triv%0d_prime", triv_n[i]), prime, triv_p[i]);
      check($sformatf("triv%0d_factor", triv_n[i]), factor, triv_f[i]);
      check($sformatf("triv%0d_trials", triv_n[i]), trials, 16'd0);
    end

    run_check("n3", 16'd3, 1'b1, 16'd0, 16'd1);
    run_check("n9", 16'd9, 1'b0, 16'd3, 16'd1);
    run_check("n49", 16'd49, 1'b0, 16'd7, 16'd3);
    run_check("n97", 16'd97, 1'b1, 16'd0, 16'd5);
    run_check("n65521", 16'd65521, 1'b1, 16'd0, 16'd128);
    run_check("n65535", 16'd65535, 1'b0, 16'd3, 16'd1);
    run_check("n63001", 16'd63001, 1'b0, 16'd251, 16'd125);

    // Results hold while idle.
    repeat (4) @(negedge clk);
    check("hold_factor", factor, 16'd251);
    check("hold_trials", trials, 16'd125);

    // go pulses while busy are ignored.
    go = 1'b1;
    n  = 16'd97;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    go = 1'b1;
    n  = 16'd15;
    @(negedge clk);
    go = 1'b0;
    repeat (20) @(negedge clk);
    go = 1'b1;
    n  = 16'd25;
    @(negedge clk);
    go = 1'b0;
    wait_ready(5000, low_cyc);
    check("busy_go_done", ready, 1'b1);
    check("busy_go_prime", prime, 1'b1);
    check("busy_go_factor", factor, 16'd0);
    check("busy_go_trials", trials, 16'd5);

    // Back-to-back go in the first ready cycle.
    run_check("b2b_n9", 16'd9, 1'b0, 16'd3, 16'd1);
    run_check("b2b_n25", 16'd25, 1'b0, 16'd5, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
